// File: rtl/dualport_sram_mr.sv
// Multi-read-port SRAM model: one bit-masked write port, NREAD read ports,
// optional write-to-read bypass and output register, and a sequential clear sweep.
module dualport_sram_mr #(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned NREAD    = 2,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          OUTREG   = 1'b0
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      CLR,
  output logic                      READY,
  input  logic                      WEB,
  input  logic [DEPTH-1:0]          AA,
  input  logic [BITWIDTH-1:0]       D,
  input  logic [BITWIDTH-1:0]       BWEB,
  input  logic [NREAD-1:0]          REB,
  input  logic [NREAD*DEPTH-1:0]    AB,
  output logic [NREAD*BITWIDTH-1:0] Q,
  output logic [NREAD-1:0]          QV
);

  localparam int unsigned WORDS = 32'd1 << DEPTH;

  typedef enum logic {INIT, RUN} state_t;

  state_t                      state;
  logic [DEPTH-1:0]            cnt;
  logic [BITWIDTH-1:0]         mem [WORDS];
  logic [BITWIDTH-1:0]         wr_merge_c;
  logic [NREAD*BITWIDTH-1:0]   rd_c;
  logic [NREAD*BITWIDTH-1:0]   s1_data;
  logic [NREAD-1:0]            s1_vld;
  logic                        run_c;

  assign run_c      = (state == RUN);
  assign wr_merge_c = (mem[AA] & ~BWEB) | (D & BWEB);

  // Sweep / run control; READY is a registered copy of the RUN state.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= INIT;
      cnt   <= '0;
      READY <= 1'b0;
    end else if (state == INIT) begin
      if (CLR) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DEPTH'(1);
        if (cnt == '1) begin
          state <= RUN;
          READY <= 1'b1;
        end
      end
    end else if (CLR) begin
      state <= INIT;
      cnt   <= '0;
      READY <= 1'b0;
    end
  end

  // Array storage: the sweep owns the write port while in INIT.
  always_ff @(posedge CLK) begin
    if (!run_c) begin
      mem[cnt] <= '0;
    end else if (WEB) begin
      mem[AA] <= wr_merge_c;
    end
  end

  // Per-port read data, with optional forwarding of the colliding write.
  always_comb begin
    rd_c = '0;
    for (int i = 0; i < int'(NREAD); i++) begin
      rd_c[i*BITWIDTH +: BITWIDTH] = mem[AB[i*DEPTH +: DEPTH]];
      if (BYPASS && WEB && (AA == AB[i*DEPTH +: DEPTH])) begin
        rd_c[i*BITWIDTH +: BITWIDTH] = wr_merge_c;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      s1_data <= '0;
      s1_vld  <= '0;
    end else begin
      for (int i = 0; i < int'(NREAD); i++) begin
        s1_vld[i] <= run_c & REB[i];
        if (run_c && REB[i]) begin
          s1_data[i*BITWIDTH +: BITWIDTH] <= rd_c[i*BITWIDTH +: BITWIDTH];
        end
      end
    end
  end

  generate
    if (OUTREG) begin : g_outreg
      // Second stage holds the stage-1 snapshot; later writes cannot reach it.
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          Q  <= '0;
          QV <= '0;
        end else begin
          QV <= s1_vld;
          for (int i = 0; i < int'(NREAD); i++) begin
            if (s1_vld[i]) begin
              Q[i*BITWIDTH +: BITWIDTH] <= s1_data[i*BITWIDTH +: BITWIDTH];
            end
          end
        end
      end
    end else begin : g_direct
      assign Q  = s1_data;
      assign QV = s1_vld;
    end
  endgenerate

endmodule

// File: tb/tb_dualport_sram_mr.sv
// Scoreboard bench: two instances (bypass/latency-1 and no-bypass/latency-2)
// share stimulus; a reference memory predicts every read result.
module tb_dualport_sram_mr;

  localparam int unsigned BW = 32;
  localparam int unsigned DW = 4;
  localparam int unsigned NR = 3;

  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
  } exp_t;

  logic          CLK, RSTN, CLR, WEB;
  logic [3:0]    AA;
  logic [31:0]   D, BWEB;
  logic [2:0]    REB;
  logic [11:0]   AB;
  logic          ready_a, ready_b;
  logic [95:0]   q_a, q_b;
  logic [2:0]    qv_a, qv_b;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            edge_n  = 0;
  logic [31:0]   mem_m [16];
  logic          m_ready;
  logic [3:0]    m_cnt;
  exp_t          sb [2][$];
  logic [31:0]   last_q [2][3];

  dualport_sram_mr #(.BITWIDTH(BW), .DEPTH(DW), .NREAD(NR), .BYPASS(1'b1), .OUTREG(1'b0)) dut_a (
    .CLK(CLK), .RSTN(RSTN), .CLR(CLR), .READY(ready_a), .WEB(WEB), .AA(AA), .D(D),
    .BWEB(BWEB), .REB(REB), .AB(AB), .Q(q_a), .QV(qv_a));

  dualport_sram_mr #(.BITWIDTH(BW), .DEPTH(DW), .NREAD(NR), .BYPASS(1'b0), .OUTREG(1'b1)) dut_b (
    .CLK(CLK), .RSTN(RSTN), .CLR(CLR), .READY(ready_b), .WEB(WEB), .AA(AA), .D(D),
    .BWEB(BWEB), .REB(REB), .AB(AB), .Q(q_b), .QV(qv_b));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    m_cnt   = '0;
    for (int k = 0; k < 2; k++) begin
      sb[k].delete();
      for (int i = 0; i < 3; i++) last_q[k][i] = '0;
    end
  endtask

  task automatic compare();
    exp_t        e;
    logic [2:0]  ev;
    logic [95:0] eq;
    check("ready_a", 96'(ready_a), 96'(m_ready));
    check("ready_b", 96'(ready_b), 96'(m_ready));
    for (int k = 0; k < 2; k++) begin
      ev = '0;
      while (sb[k].size() > 0 && sb[k][0].due <= edge_n) begin
        e = sb[k].pop_front();
        ev[e.port] = 1'b1;
        last_q[k][e.port] = e.data;
      end
      eq = {last_q[k][2], last_q[k][1], last_q[k][0]};
      check($sformatf("qv_%0d", k), 96'(k == 0 ? qv_a : qv_b), 96'(ev));
      check($sformatf("q_%0d", k), (k == 0 ? q_a : q_b), eq);
    end
  endtask

  task automatic step(input logic clr, input logic web, input logic [3:0] aa,
                      input logic [31:0] d, input logic [31:0] bweb, input logic [2:0] reb,
                      input logic [3:0] ab0, input logic [3:0] ab1, input logic [3:0] ab2);
    logic [3:0]  ab [3];
    logic [31:0] merged;
    logic [31:0] rd;
    ab[0] = ab0; ab[1] = ab1; ab[2] = ab2;
    CLR = clr; WEB = web; AA = aa; D = d; BWEB = bweb; REB = reb; AB = {ab2, ab1, ab0};
    if (m_ready) begin
      merged = (mem_m[aa] & ~bweb) | (d & bweb);
      for (int i = 0; i < 3; i++) begin
        if (reb[i]) begin
          rd = (web && aa == ab[i]) ? merged : mem_m[ab[i]];
          sb[0].push_back('{due: edge_n + 1, port: i, data: rd});
          sb[1].push_back('{due: edge_n + 2, port: i, data: mem_m[ab[i]]});
        end
      end
      if (web) mem_m[aa] = merged;
      if (clr) begin
        m_ready = 1'b0;
        m_cnt   = '0;
      end
    end else begin
      mem_m[m_cnt] = '0;
      if (clr) begin
        m_cnt = '0;
      end else begin
        if (m_cnt == 4'hF) m_ready = 1'b1;
        m_cnt = m_cnt + 4'd1;
      end
    end
    @(posedge CLK);
    edge_n++;
    #1;
    compare();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 3'b000, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [31:0] m);
    step(1'b0, 1'b1, a, d, m, 3'b000, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic rd3(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
    step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 3'b111, a0, a1, a2);
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_ready_a"}, 96'(ready_a), 96'd0);
    check({tag, "_ready_b"}, 96'(ready_b), 96'd0);
    check({tag, "_q_a"}, q_a, 96'd0);
    check({tag, "_q_b"}, q_b, 96'd0);
    check({tag, "_qv_a"}, 96'(qv_a), 96'd0);
    check({tag, "_qv_b"}, 96'(qv_b), 96'd0);
  endtask

  task automatic sweep_with_noise(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, 4'(i), 32'hDEAD_BEEF, 32'hFFFF_FFFF, 3'b111, 4'(i), 4'(i + 1), 4'(i + 2));
    end
  endtask

  initial begin
    RSTN = 1'b0; CLR = 1'b0; WEB = 1'b0; AA = '0; D = '0; BWEB = '0; REB = '0; AB = '0;
    for (int i = 0; i < 16; i++) mem_m[i] = 32'hBAD0_0000 | 32'(i);
    model_reset();
    #12;
    reset_values("rst");
    @(negedge CLK);
    RSTN = 1'b1;

    // Initial sweep: writes and reads during INIT must have no effect.
    sweep_with_noise(15);
    check("ready_low_at_15", 96'(ready_a), 96'd0);
    sweep_with_noise(1);
    check("ready_high_at_16", 96'(ready_a), 96'd1);
    for (int i = 0; i < 16; i++) rd3(4'(i), 4'(15 - i), 4'(i));
    idle(); idle();

    // Masked write
    wr(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wr(4'd3, 32'h1234_5678, 32'h0000_FFFF);
    rd3(4'd3, 4'd3, 4'd3);
    check("masked_q0", 96'(q_a[31:0]), 96'(32'hFFFF_5678));
    idle(); idle();

    // Bypass collision
    wr(4'd5, 32'hAAAA_AAAA, 32'hFFFF_FFFF);
    step(1'b0, 1'b1, 4'd5, 32'h5555_5555, 32'hFFFF_0000, 3'b001, 4'd5, 4'd0, 4'd0);
    check("bypass_q0", 96'(q_a[31:0]), 96'(32'h5555_AAAA));
    idle();
    check("nobypass_q0", 96'(q_b[31:0]), 96'(32'hAAAA_AAAA));
    step(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 3'b001, 4'd5, 4'd0, 4'd0);
    idle();
    check("nobypass_later_q0", 96'(q_b[31:0]), 96'(32'h5555_AAAA));
    idle();

    // Multi-port same-cycle reads
    wr(4'd1, 32'h11, 32'hFFFF_FFFF);
    wr(4'd7, 32'h77, 32'hFFFF_FFFF);
    rd3(4'd1, 4'd1, 4'd7);
    check("mp_q", q_a, {32'h77, 32'h11, 32'h11});
    check("mp_qv", 96'(qv_a), 96'(3'b111));
    idle();
    check("mp_hold_qv", 96'(qv_a), 96'd0);
    idle();

    // Random traffic with frequent address collisions
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom,
           3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)));
    end
    idle(); idle();

    // CLR with reads in flight, noise during sweep, second CLR 3 edges in
    wr(4'd9, 32'hC0FF_EE00, 32'hFFFF_FFFF);
    rd3(4'd9, 4'd7, 4'd1);
    step(1'b1, 1'b1, 4'd2, 32'h0BAD_F00D, 32'hFFFF_FFFF, 3'b111, 4'd9, 4'd2, 4'd3);
    check("clr_ready_fall", 96'(ready_a), 96'd0);
    sweep_with_noise(2);
    step(1'b1, 1'b1, 4'd0, 32'h1111_1111, 32'hFFFF_FFFF, 3'b111, 4'd0, 4'd0, 4'd0);
    sweep_with_noise(15);
    check("clr2_ready_low", 96'(ready_a), 96'd0);
    sweep_with_noise(1);
    check("clr2_ready_high", 96'(ready_a), 96'd1);
    for (int i = 0; i < 16; i++) rd3(4'(i), 4'(i), 4'(15 - i));
    idle(); idle();

    // Async reset in the middle of a sweep
    wr(4'd2, 32'h2222_2222, 32'hFFFF_FFFF);
    wr(4'd4, 32'h4444_4444, 32'hFFFF_FFFF);
    rd3(4'd2, 4'd4, 4'd2);
    idle(); idle();
    step(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 3'b000, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 7; i++) idle();
    #2;
    RSTN = 1'b0;
    #1;
    reset_values("async");
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    sweep_with_noise(15);
    check("resweep_ready_low", 96'(ready_b), 96'd0);
    sweep_with_noise(1);
    check("resweep_ready_high", 96'(ready_b), 96'd1);
    for (int i = 0; i < 16; i++) rd3(4'(i), 4'(i), 4'(i));
    idle(); idle(); idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dualport_sram_mr.md
# dualport_sram_mr

Parametrised successor to the team's 1W/1R dual-port SRAM model: one bit-masked write port, `NREAD` independent read ports, and selectable write-to-read bypass. Optional output register stage. Memory is cleared by a sequential sweep after reset, or on request, instead of a single-cycle array reset. Used for register-file and cache-tag/data storage in the SM pipeline wherever multiple operand reads per cycle are needed.

## Interface
Parameters:
- `BITWIDTH`, 32 — data word width.
- `DEPTH`, 8 — address width; the array holds 2**DEPTH words.
- `NREAD`, 2 — number of read ports, 1..8.
- `BYPASS`, 1 — 1: same-cycle write data is forwarded to a matching read; 0: the read returns the old contents.
- `OUTREG`, 0 — 0: read latency 1; 1: extra output register, read latency 2.

Ports. One clock; reset is asynchronous and active-low.
- `CLK  in  1` — clock, rising edge.
- `RSTN  in  1` — asynchronous active-low reset.
- `CLR  in  1` — request a clear sweep; single-cycle pulse.
- `READY  out  1` — array usable; low during the sweep.
- `WEB  in  1` — write enable, active high.
- `AA  in  DEPTH` — write address.
- `D  in  BITWIDTH` — write data.
- `BWEB  in  BITWIDTH` — per-bit write mask; 1 = write that bit.
- `REB  in  NREAD` — per-port read enable, active high.
- `AB  in  NREAD*DEPTH` — read addresses; port i uses bits [i*DEPTH +: DEPTH].
- `Q  out  NREAD*BITWIDTH` — read data; port i uses bits [i*BITWIDTH +: BITWIDTH].
- `QV  out  NREAD` — per-port read-data-valid pulse.

## Operation
- States: `INIT` (sweep) and `RUN`. A DEPTH-bit sweep counter `cnt` is used in `INIT`.
- Reset: state=`INIT`, cnt=0, READY=0, Q=0, QV=0, pipeline registers=0. Array contents are not reset directly.
- `INIT`: each edge writes all-zeros to mem[cnt], then cnt increments.
  - On the edge that clears address 2**DEPTH-1: state→`RUN`, READY=1.
  - WEB and REB are ignored; QV stays 0.
  - A CLR seen in `INIT` restarts the sweep: cnt=0.
- `RUN`:
  - CLR=1 → state `INIT`, cnt=0, READY=0 on the next edge. The WEB/REB sampled on that same edge are still serviced.
  - A read issued on the CLR edge still completes with its normal latency.
  - Reads that are still in the pipeline when `INIT` is entered also complete with their normal latency.
- Write (`RUN`, WEB=1): for each bit b with BWEB[b]=1, mem[AA][b] ← D[b]. Other bits are unchanged. BWEB=0 with WEB=1 is a legal no-op.
- Read port i (`RUN`, REB[i]=1): stage-1 register captures rd_i.
  - With BYPASS=1 and WEB & (AA==AB_i): rd_i = (mem[AB_i] & ~BWEB) | (D & BWEB).
  - Otherwise: rd_i = mem[AB_i], the pre-edge contents.
- Any number of ports may read the same address in one cycle. Each port is independent.
- Write/read address collisions are legal; behaviour is set by BYPASS.
- Q holds its last value when no read completes. QV[i]=1 for exactly one cycle per accepted read.

## Timing
- OUTREG=0: REB sampled at edge N → Q/QV valid after edge N; QV drops after edge N+1 unless REB is held.
- OUTREG=1: Q/QV valid after edge N+1.
- Back-to-back reads on every cycle give full throughput: one result per port per cycle.
- Data read is a snapshot at edge N. A write at edge N+1 does not alter a result in the OUTREG stage.
- Sweep length: READY rises after exactly 2**DEPTH edges following RSTN deassertion or the CLR edge.
- The first write is accepted on the edge at which READY is already 1.
- An asynchronous RSTN assertion at any time immediately forces the reset values above, including in the middle of a sweep.

## Test plan
- **Reset/sweep:** DEPTH=4. Release RSTN → READY=0 for 16 edges, then 1. Read all 16 addresses → Q=0 and QV pulses, with latency 1 (OUTREG=0) and 2 (OUTREG=1).
- **Masked write:** write 0xFFFFFFFF to addr 3, then D=0x12345678 with BWEB=0x0000FFFF → read addr 3 = 0xFFFF5678.
- **Bypass collision:** addr 5 = 0xAAAAAAAA. Same cycle: WEB=1, AA=5, D=0x55555555, BWEB=0xFFFF0000, and REB[0]=1, AB0=5.
  - BYPASS=1 → Q0 = 0x5555AAAA.
  - BYPASS=0 → Q0 = 0xAAAAAAAA; a subsequent read returns 0x5555AAAA.
- **Multi-port:** NREAD=3, ports read addrs 1, 1, 7 (holding 0x11, 0x11, 0x77) in the same cycle → Q = {0x77, 0x11, 0x11} and QV = 3'b111. Next cycle with REB=0 → QV=0 and Q is held.
- **CLR mid-operation:**
  - With a read in flight, pulse CLR → the in-flight read returns its correct data and READY falls.
  - WEB pulses during the sweep are ignored; after READY, all addresses read 0.
  - A second CLR 3 cycles into the sweep extends READY-low to 3+16 edges.
- **Async reset mid-sweep:** assert RSTN at cnt=7 → READY=0, Q=0, QV=0 immediately. After release, a full 16-edge sweep runs.
